// File: rtl/tmds_pkg.sv
// Shared TMDS types, control/guard-band code words and bit-count helpers
// used by the per-channel encoder and the three-channel top level.
package tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  localparam tmds_word_t CTL_00 = 10'b1101010100;
  localparam tmds_word_t CTL_01 = 10'b0010101011;
  localparam tmds_word_t CTL_10 = 10'b0101010100;
  localparam tmds_word_t CTL_11 = 10'b1010101011;

  localparam tmds_word_t GB_BLUE  = 10'b1011001100;
  localparam tmds_word_t GB_GREEN = 10'b0100110011;
  localparam tmds_word_t GB_RED   = 10'b1011001100;

  // One pixel clock worth of source inputs, as carried by the guard-band delay line.
  typedef struct packed {
    logic       vde;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pix_t;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic tmds_word_t ctl_word(input logic [1:0] c);
    tmds_word_t w;
    case (c)
      2'b00:   w = CTL_00;
      2'b01:   w = CTL_01;
      2'b10:   w = CTL_10;
      default: w = CTL_11;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tmds_encoder_ch.sv
// One TMDS channel: stage 1 builds the transition-minimised q_m word, stage 2
// applies DC balancing with a 5-bit running disparity or emits control/guard words.
module tmds_encoder_ch
  import tmds_pkg::*;
#(
  parameter tmds_word_t kGuard = GB_BLUE
) (
  input  logic       PixelClk,
  input  logic       aRst,
  input  logic       pVde,
  input  logic [1:0] pC,
  input  logic [7:0] pD,
  input  logic       pGuard,
  output logic [9:0] pTmds
);

  logic [3:0] n1_data;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  logic       vde_q;
  logic [1:0] c_q;
  logic       guard_q;

  always_comb begin
    n1_data  = popcount8(pD);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !pD[0]);
    qm_d     = '0;
    qm_d[0]  = pD[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ pD[i]) : (qm_d[i-1] ^ pD[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      vde_q   <= 1'b0;
      c_q     <= 2'b00;
      guard_q <= 1'b0;
      qm_q    <= '0;
    end else begin
      vde_q   <= pVde;
      c_q     <= pC;
      guard_q <= pGuard;
      qm_q    <= qm_d;
    end
  end

  logic [3:0] n1_qm;
  logic [4:0] diff;
  logic [4:0] bias_xor;
  logic [4:0] bias_xnor;
  logic       cnt_pos;
  logic       cnt_neg;
  logic       diff_pos;
  logic       diff_neg;
  logic [4:0] cnt_d;
  logic [4:0] cnt_q;
  tmds_word_t tmds_d;
  tmds_word_t tmds_q;

  // diff and cnt are two's-complement modulo 32; diff = n1 - n0 = 2*n1 - 8.
  always_comb begin
    n1_qm     = popcount8(qm_q[7:0]);
    diff      = {n1_qm, 1'b0} - 5'd8;
    bias_xor  = {3'b000, qm_q[8], 1'b0};
    bias_xnor = {3'b000, ~qm_q[8], 1'b0};
    cnt_pos   = !cnt_q[4] && (cnt_q != 5'd0);
    cnt_neg   = cnt_q[4];
    diff_pos  = !diff[4] && (diff != 5'd0);
    diff_neg  = diff[4];
    tmds_d    = tmds_q;
    cnt_d     = cnt_q;
    if (!vde_q) begin
      tmds_d = guard_q ? kGuard : ctl_word(c_q);
      cnt_d  = 5'd0;
    end else if ((cnt_q == 5'd0) || (diff == 5'd0)) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + bias_xor - diff;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q + diff - bias_xnor;
    end
  end

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      tmds_q <= CTL_00;
      cnt_q  <= 5'd0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pTmds = tmds_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI TMDS encoder (blue=Data0, green=Data1, red=Data2).
// Define TMDS_GUARD_BAND_EN to add HDMI video guard bands (latency 2 -> 4).
module tmds_encoder_3ch
  import tmds_pkg::*;
#(
  parameter logic [1:0] kCtlDefault = 2'b00
) (
  input  logic       PixelClk,
  input  logic       aRst,
  input  logic       pVde,
  input  logic       pHSync,
  input  logic       pVSync,
  input  logic [7:0] pRed,
  input  logic [7:0] pGreen,
  input  logic [7:0] pBlue,
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_b
);

  pix_t pix_in;
  pix_t src;
  logic guard;

  assign pix_in = {pVde, pHSync, pVSync, pRed, pGreen, pBlue};

`ifdef TMDS_GUARD_BAND_EN
  pix_t dly1_q;
  pix_t dly2_q;

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      dly1_q <= '0;
      dly2_q <= '0;
    end else begin
      dly1_q <= pix_in;
      dly2_q <= dly1_q;
    end
  end

  // The two blanking words immediately preceding a rising vde become guard bands.
  assign src   = dly2_q;
  assign guard = !dly2_q.vde && (dly1_q.vde || pVde);
`else
  assign src   = pix_in;
  assign guard = 1'b0;
`endif

  logic [7:0] ch_data [3];
  logic [1:0] ch_ctl  [3];
  logic [9:0] ch_tmds [3];

  assign ch_data[0] = src.blue;
  assign ch_data[1] = src.green;
  assign ch_data[2] = src.red;
  assign ch_ctl[0]  = {src.vsync, src.hsync};
  assign ch_ctl[1]  = kCtlDefault;
  assign ch_ctl[2]  = kCtlDefault;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      localparam tmds_word_t kGuard = (gi == 0) ? GB_BLUE : ((gi == 1) ? GB_GREEN : GB_RED);
      tmds_encoder_ch #(
        .kGuard (kGuard)
      ) u_ch (
        .PixelClk (PixelClk),
        .aRst     (aRst),
        .pVde     (src.vde),
        .pC       (ch_ctl[gi]),
        .pD       (ch_data[gi]),
        .pGuard   (guard),
        .pTmds    (ch_tmds[gi])
      );
    end
  endgenerate

  assign tmds_b = ch_tmds[0];
  assign tmds_g = ch_tmds[1];
  assign tmds_r = ch_tmds[2];

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Directed and scoreboarded checks of the three-channel TMDS encoder (default build).
module tb_tmds_encoder_3ch;

  logic       PixelClk;
  logic       aRst;
  logic       pVde;
  logic       pHSync;
  logic       pVSync;
  logic [7:0] pRed;
  logic [7:0] pGreen;
  logic [7:0] pBlue;
  logic [9:0] tmds_r;
  logic [9:0] tmds_g;
  logic [9:0] tmds_b;

  int tests_run;
  int tests_failed;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  localparam int NRND = 200;
  logic [9:0] exp_b [NRND];
  logic [9:0] exp_g [NRND];
  logic [9:0] exp_r [NRND];

  tmds_encoder_3ch #(
    .kCtlDefault (2'b00)
  ) dut (
    .PixelClk (PixelClk),
    .aRst     (aRst),
    .pVde     (pVde),
    .pHSync   (pHSync),
    .pVSync   (pVSync),
    .pRed     (pRed),
    .pGreen   (pGreen),
    .pBlue    (pBlue),
    .tmds_r   (tmds_r),
    .tmds_g   (tmds_g),
    .tmds_b   (tmds_b)
  );

  initial PixelClk = 1'b0;
  always #5 PixelClk = ~PixelClk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("[TB] %s ok %b", tag, got);
    end
  endtask

  // Apply one pixel-clock's inputs, then sample 1 ns after the rising edge.
  task automatic cycle(input logic vde, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pVde   = vde;
    pHSync = hs;
    pVSync = vs;
    pRed   = r;
    pGreen = g;
    pBlue  = b;
    @(posedge PixelClk);
    #1;
  endtask

  task automatic model_ch(input logic vde, input logic [1:0] c, input logic [7:0] d,
                          input int cnt_in, output logic [9:0] w, output int cnt_out);
    int         n1d;
    int         n1q;
    int         n0q;
    logic [8:0] qm;
    if (!vde) begin
      case (c)
        2'b00:   w = C00;
        2'b01:   w = C01;
        2'b10:   w = C10;
        default: w = C11;
      endcase
      cnt_out = 0;
      return;
    end
    n1d = $countones(d);
    qm  = '0;
    qm[0] = d[0];
    if ((n1d > 4) || ((n1d == 4) && (d[0] == 1'b0))) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if ((cnt_in == 0) || (n1q == n0q)) begin
      w       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if (((cnt_in > 0) && (n1q > n0q)) || ((cnt_in < 0) && (n0q > n1q))) begin
      w       = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      w       = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in + n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  initial begin
    int          cb;
    int          cg;
    int          cr;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    tests_run    = 0;
    tests_failed = 0;
    aRst   = 1'b1;
    pVde   = 1'b0;
    pHSync = 1'b0;
    pVSync = 1'b0;
    pRed   = 8'h00;
    pGreen = 8'h00;
    pBlue  = 8'h00;

    // Reset held
    repeat (3) @(posedge PixelClk);
    #1;
    check("rst_b", tmds_b, C00);
    check("rst_g", tmds_g, C00);
    check("rst_r", tmds_r, C00);
    @(negedge PixelClk);
    aRst = 1'b0;

    // Steady blanking after release
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("blank_b", tmds_b, C00);
    check("blank_g", tmds_g, C00);
    check("blank_r", tmds_r, C00);

    // HSync in blanking drives blue C0 only
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    check("hs_b", tmds_b, C01);
    check("hs_g", tmds_g, C00);
    check("hs_r", tmds_r, C00);

    // Stream of zeros: disparity alternates -8, 2, -6, 4, -4
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("zero1_b", tmds_b, 10'b0100000000);
    check("zero1_g", tmds_g, 10'b0100000000);
    check("zero1_r", tmds_r, 10'b0100000000);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("zero2_b", tmds_b, 10'b1111111111);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("zero3_b", tmds_b, 10'b0100000000);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("zero4_b", tmds_b, 10'b1111111111);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("zero5_b", tmds_b, 10'b0100000000);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("toblank_b", tmds_b, C00);

    // 0xFF right after blanking needs cnt cleared to 0, then 0x00 sees cnt=-8
    cycle(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("ff_b", tmds_b, 10'b1000000000);
    check("ff_g", tmds_g, 10'b1000000000);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("ff_then0_b", tmds_b, 10'b1111111111);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("ff_blank_b", tmds_b, C00);

    // Asynchronous reset mid-line
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("pre_rst_b", tmds_b, 10'b0100000000);
    #2;
    aRst = 1'b1;
    #1;
    check("async_rst_b", tmds_b, C00);
    check("async_rst_g", tmds_g, C00);
    check("async_rst_r", tmds_r, C00);
    @(negedge PixelClk);
    aRst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    check("post_rst_ctl_b", tmds_b, C00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("post_rst_ff_b", tmds_b, 10'b1000000000);

    // Random line with sync/blank toggling against the reference model
    cb = 0;
    cg = 0;
    cr = 0;
    for (int k = 0; k < NRND; k++) begin
      if (k < 2) begin
        vde = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        r   = 8'h00;
        g   = 8'h00;
        b   = 8'h00;
      end else begin
        vde = ($urandom_range(0, 9) < 8);
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        r   = 8'($urandom_range(0, 255));
        g   = 8'($urandom_range(0, 255));
        b   = 8'($urandom_range(0, 255));
      end
      model_ch(vde, {vs, hs}, b, cb, exp_b[k], cb);
      model_ch(vde, 2'b00,    g, cg, exp_g[k], cg);
      model_ch(vde, 2'b00,    r, cr, exp_r[k], cr);
      cycle(vde, hs, vs, r, g, b);
      if (k >= 1) begin
        check($sformatf("rnd%0d_b", k - 1), tmds_b, exp_b[k-1]);
        check($sformatf("rnd%0d_g", k - 1), tmds_g, exp_g[k-1]);
        check($sformatf("rnd%0d_r", k - 1), tmds_r, exp_r[k-1]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
